// File: rtl/clk_div_mon_pkg.sv
// Shared state type and sizing helpers for the divided-clock monitor.
package clk_div_mon_pkg;

    typedef enum logic [0:0] {
        ACQ    = 1'b0,
        LOCKED = 1'b1
    } mon_state_e;

    localparam int unsigned LOCK_CNT_MAX = 15;

    // Width of the consecutive-match counter for a given lock threshold.
    function automatic int unsigned mcnt_width(input int unsigned lock_cnt);
        return $clog2(lock_cnt + 1);
    endfunction

endpackage

// File: rtl/clk_div_monitor_sync.sv
// Two-flop synchroniser with a history flop; yields the synchronised level and a rising-edge strobe.
module sync_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c,
    output logic level
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;
    assign level  = s2;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high time of a divided clock in source-clock cycles and tracks lock to a programmed ratio.
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_clk_i,
    input  logic [CNT_W-1:0] cfg_ratio_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             period_vld_o,
    output logic             locked_o,
    output logic             err_o,
    output logic             dead_o
);

    localparam int unsigned      MCNT_W  = mcnt_width(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              rise;
    logic              level;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  hcnt;
    logic              first_seen;
    logic [MCNT_W-1:0] mcnt;
    mon_state_e        state;

    logic              valid;
    logic              match;
    logic              stall;
    logic              sat;
    logic [CNT_W:0]    ratio_p1;

    sync_rise_det u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (div_clk_i),
        .rise_c (rise),
        .level  (level)
    );

    // Ratio+1 is one bit wider so a full-scale ratio never wraps onto a small count.
    always_comb begin
        ratio_p1 = {1'b0, cfg_ratio_i} + (CNT_W + 1)'(1);
        valid    = rise & first_seen;
        match    = (cnt == cfg_ratio_i) && (cfg_ratio_i >= CNT_W'(2));
        stall    = !rise && ({1'b0, cnt} == ratio_p1);
        sat      = !rise && (cnt == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            hcnt         <= '0;
            first_seen   <= 1'b0;
            mcnt         <= '0;
            state        <= ACQ;
            period_o     <= '0;
            high_o       <= '0;
            period_vld_o <= 1'b0;
            locked_o     <= 1'b0;
            err_o        <= 1'b0;
            dead_o       <= 1'b0;
        end else begin
            period_vld_o <= 1'b0;
            err_o        <= 1'b0;

            if (rise) begin
                cnt  <= CNT_W'(1);
                hcnt <= CNT_W'(1);
            end else begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                if (level && (hcnt != CNT_MAX)) hcnt <= hcnt + CNT_W'(1);
            end

            // A rise always re-arms; saturation without a rise declares the clock dead.
            if (rise) begin
                first_seen <= 1'b1;
                dead_o     <= 1'b0;
            end else if (sat) begin
                first_seen <= 1'b0;
                dead_o     <= 1'b1;
            end

            if (valid) begin
                period_o     <= cnt;
                high_o       <= hcnt;
                period_vld_o <= 1'b1;
            end

            case (state)
                ACQ: begin
                    if (valid) begin
                        if (!match) begin
                            mcnt <= '0;
                        end else if (mcnt == MCNT_W'(LOCK_CNT - 1)) begin
                            mcnt     <= '0;
                            locked_o <= 1'b1;
                            state    <= LOCKED;
                        end else begin
                            mcnt <= mcnt + MCNT_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if ((valid && !match) || stall) begin
                        err_o    <= 1'b1;
                        locked_o <= 1'b0;
                        mcnt     <= '0;
                        state    <= ACQ;
                    end
                end
                default: state <= ACQ;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: table vectors, hand-built corner sequences and random periods vs a timestamp model.
module tb_clk_div_monitor;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;
    localparam int MAXC     = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             div_clk_i;
    logic [CNT_W-1:0] cfg_ratio;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             period_vld_o;
    logic             locked_o;
    logic             err_o;
    logic             dead_o;

    clk_div_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_clk_i    (div_clk_i),
        .cfg_ratio_i  (cfg_ratio),
        .period_o     (period_o),
        .high_o       (high_o),
        .period_vld_o (period_vld_o),
        .locked_o     (locked_o),
        .err_o        (err_o),
        .dead_o       (dead_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: works from the list of sampled levels and the timestamp of the last rise.
    int k;
    bit dh[$];
    int cfg;
    int anchor;
    bit m_first, m_dead, m_locked, m_vld, m_err;
    int m_mcnt, m_period, m_high;

    int errs_seen, vld_seen, dead_seen, locked_seen;
    int pq[$];

    typedef struct {
        int ratio;
        int hi;
        int lo;
        int nper;
        int exp_period;
        int exp_high;
        int exp_locked;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, k);
        end
    endtask

    // Level seen by the detector at edge kk: the input driven two edges earlier.
    function automatic bit lvl(input int kk);
        if (kk < 3) return 1'b0;
        return dh[kk-3];
    endfunction

    task automatic model_reset();
        k = 0;
        dh.delete();
        anchor   = 1;
        m_first  = 0;
        m_dead   = 0;
        m_locked = 0;
        m_vld    = 0;
        m_err    = 0;
        m_mcnt   = 0;
        m_period = 0;
        m_high   = 0;
    endtask

    task automatic clear_tallies();
        errs_seen   = 0;
        vld_seen    = 0;
        dead_seen   = 0;
        locked_seen = 0;
        pq.delete();
    endtask

    task automatic model_edge();
        bit rise;
        bit match;
        int since;
        int h;
        rise  = lvl(k) && !lvl(k-1);
        since = k - anchor;
        if (since > MAXC) since = MAXC;
        m_vld = 0;
        m_err = 0;
        if (rise) begin
            if (m_first) begin
                h = 0;
                for (int j = anchor; j < k; j++) h += int'(lvl(j));
                if (h > MAXC) h = MAXC;
                m_period = since;
                m_high   = h;
                m_vld    = 1;
                match    = (since == cfg) && (cfg >= 2);
                if (!m_locked) begin
                    if (match) begin
                        m_mcnt++;
                        if (m_mcnt == LOCK_CNT) begin
                            m_locked = 1;
                            m_mcnt   = 0;
                        end
                    end else begin
                        m_mcnt = 0;
                    end
                end else if (!match) begin
                    m_err    = 1;
                    m_locked = 0;
                    m_mcnt   = 0;
                end
            end
            m_first = 1;
            m_dead  = 0;
            anchor  = k;
        end else begin
            if (m_locked && since == cfg + 1) begin
                m_err    = 1;
                m_locked = 0;
                m_mcnt   = 0;
            end
            if (since == MAXC) begin
                m_dead  = 1;
                m_first = 0;
            end
        end
    endtask

    task automatic set_cfg(input int v);
        cfg       = v;
        cfg_ratio = CNT_W'(v);
    endtask

    // One source-clock cycle: drive at the falling edge, check #1 after the rising edge.
    task automatic step(input bit din);
        div_clk_i = din;
        @(posedge clk);
        k++;
        dh.push_back(din);
        model_edge();
        #1;
        check("period_o", int'(period_o), m_period);
        check("high_o", int'(high_o), m_high);
        check("period_vld_o", int'(period_vld_o), int'(m_vld));
        check("locked_o", int'(locked_o), int'(m_locked));
        check("err_o", int'(err_o), int'(m_err));
        check("dead_o", int'(dead_o), int'(m_dead));
        if (err_o) errs_seen++;
        if (dead_o) dead_seen++;
        if (locked_o) locked_seen++;
        if (period_vld_o) begin
            vld_seen++;
            pq.push_back(int'(period_o));
        end
        @(negedge clk);
    endtask

    task automatic period(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, int'(period_o), 0);
        check({tag, "_high"}, int'(high_o), 0);
        check({tag, "_vld"}, int'(period_vld_o), 0);
        check({tag, "_locked"}, int'(locked_o), 0);
        check({tag, "_err"}, int'(err_o), 0);
        check({tag, "_dead"}, int'(dead_o), 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        div_clk_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_tallies();
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear before the next edge.
    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int len, hi;
        rst_n     = 1'b1;
        div_clk_i = 1'b0;
        set_cfg(3);
        model_reset();
        clear_tallies();
        #2 rst_n = 1'b0;
        #1 check_zero("reset");

        vecs[0] = '{3, 2, 1, 8, 3, 2, 1};
        vecs[1] = '{1, 1, 1, 8, 2, 1, 0};
        vecs[2] = '{5, 3, 2, 8, 5, 3, 1};
        vecs[3] = '{4, 2, 2, 8, 4, 2, 1};
        vecs[4] = '{3, 1, 3, 8, 4, 1, 0};
        vecs[5] = '{255, 1, 254, 3, 255, 1, 0};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            set_cfg(vecs[v].ratio);
            repeat (vecs[v].nper) period(vecs[v].hi, vecs[v].lo);
            step(1'b1);
            check("vec_period", int'(period_o), vecs[v].exp_period);
            check("vec_high", int'(high_o), vecs[v].exp_high);
            check("vec_locked", int'(locked_o), vecs[v].exp_locked);
            check("vec_vld_count", vld_seen, vecs[v].nper - 1);
            check("vec_err_count", errs_seen, 0);
            check("vec_dead_count", dead_seen, 0);
        end

        // Lock at 3, stretch one period to 4, then relock after four good periods.
        do_reset();
        set_cfg(3);
        repeat (8) period(2, 1);
        check("lock_div3", int'(locked_o), 1);
        clear_tallies();
        period(2, 2);
        repeat (4) period(2, 1);
        step(1'b1);
        step(1'b1);
        check("relock_early", int'(locked_o), 0);
        step(1'b1);
        check("relock", int'(locked_o), 1);
        check("stretch_err_count", errs_seen, 1);
        check("stretch_vld_count", pq.size(), 6);
        check("stretch_p0", (pq.size() > 0) ? pq[0] : -1, 3);
        check("stretch_p1", (pq.size() > 1) ? pq[1] : -1, 4);
        check("stretch_p2", (pq.size() > 2) ? pq[2] : -1, 3);

        // Locked, then the divided clock stops low.
        clear_tallies();
        repeat (300) step(1'b0);
        check("dead_err_count", errs_seen, 1);
        check("dead_level", int'(dead_o), 1);
        check("dead_cycles", dead_seen, 46);
        check("dead_locked", int'(locked_o), 0);
        clear_tallies();
        period(2, 1);
        check("restart_dead_clear", int'(dead_o), 0);
        check("restart_no_vld", vld_seen, 0);
        period(2, 1);
        check("restart_first_vld", vld_seen, 1);

        // Asynchronous reset in the middle of a locked period.
        do_reset();
        set_cfg(3);
        repeat (8) period(2, 1);
        check("pre_rst_locked", int'(locked_o), 1);
        step(1'b1);
        async_reset_check();
        clear_tallies();
        period(2, 1);
        check("post_rst_no_vld", vld_seen, 0);
        period(2, 1);
        check("post_rst_first_vld", vld_seen, 1);
        repeat (3) period(2, 1);
        check("post_rst_locked", int'(locked_o), 1);
        check("post_rst_err_count", errs_seen, 0);

        // Alternating 3/4 periods never lock.
        do_reset();
        set_cfg(3);
        repeat (6) begin
            period(2, 1);
            period(2, 2);
        end
        step(1'b1);
        check("alt_locked_seen", locked_seen, 0);
        check("alt_err_count", errs_seen, 0);
        check("alt_vld_count", pq.size(), 11);
        for (int i = 0; i < pq.size(); i++)
            check("alt_period", pq[i], (i % 2 == 0) ? 3 : 4);

        // Random periods around the programmed ratio, with ratio changes and one dead gap.
        do_reset();
        set_cfg($urandom_range(2, 6));
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 39) == 0) set_cfg($urandom_range(1, 6));
            if ($urandom_range(0, 3) != 0) len = cfg;
            else len = $urandom_range(2, 9);
            if (len < 2) len = 2;
            hi = $urandom_range(1, len - 1);
            period(hi, len - hi);
            if (i == 40) repeat (270) step(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Checker at the consuming end of a divided clock (e.g. a divide-by-3 output), running in the source clock domain.
- Synchronises the divided-clock waveform and measures its period and high time in source-clock cycles.
- Declares lock after a run of periods that match a programmed ratio.
- Flags mismatches, stalls and dead clocks, for use as a clock-health status in the clocking subsystem.

Parameters:
- CNT_W, 8: width of period/high counters; counters saturate at 2^CNT_W-1.
- LOCK_CNT, 4: consecutive matching periods required to assert locked_o (1..15).

Ports:
- clk  input  1  source clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset; one clock.
- div_clk_i  input  1  divided clock under test, treated as asynchronous data.
- cfg_ratio_i  input  CNT_W  expected period in clk cycles; quasi-static.
- period_o  output  CNT_W  last measured period.
- high_o  output  CNT_W  sampled-high cycles within last period.
- period_vld_o  output  1  one-cycle pulse when period_o/high_o update.
- locked_o  output  1  ratio locked.
- err_o  output  1  one-cycle pulse on loss of lock.
- dead_o  output  1  no rising edge for 2^CNT_W-1 cycles.

Behaviour:
- Reset (rst_n low, async): all outputs 0; counters 0; state ACQ; first_seen 0; sync flops 0.
- Sync and edge detect: 2-flop synchroniser plus one history flop. rise = s2 & ~s3. Detection latency is 3 clk edges from div_clk_i rising before setup.
- Period counter cnt:
  - On rise, cnt <= 1.
  - Otherwise, cnt <= cnt+1, saturating at max.
- High counter:
  - On rise, hcnt <= 1.
  - Otherwise, hcnt += s2, saturating.
- On rise with first_seen=1:
  - period_o <= cnt, high_o <= hcnt, period_vld_o pulses next cycle.
  - match = (cnt == cfg_ratio_i).
- On the first rise after reset or after dead: first_seen <= 1, no vld, no compare.
- State machine (ACQ, LOCKED):
  - ACQ, on valid period:
    - If match: mcnt++. When mcnt reaches LOCK_CNT, go to LOCKED and set locked_o.
    - If mismatch: mcnt <= 0.
  - LOCKED, on valid period with mismatch: err_o pulse, locked_o <= 0, mcnt <= 0, go to ACQ.
  - LOCKED stall: if cnt == cfg_ratio_i+1 with no rise, it is a late edge. err_o pulse, go to ACQ, mcnt <= 0. The next rise still yields a valid (mismatching) period with no second err.
- Boundary conditions:
  - cfg_ratio_i < 2: unmeasurable. Stay in ACQ, locked_o stays 0, period_o is still reported.
  - Dead clock: cnt saturates, then dead_o <= 1, first_seen <= 0. If LOCKED, err_o pulses once via the stall rule, not again on saturation.
    - dead_o clears on the next rise. That rise is treated as a first edge.
  - Rise in the same cycle as saturation: the rise wins. dead_o is not set, and period_o = max.
  - cfg_ratio_i change while LOCKED: handled by the normal mismatch rule; no special case.
  - Reset mid-measurement: returns to reset values immediately; no err_o is produced.
- Width rules: all compares are unsigned CNT_W. cfg_ratio_i+1 is computed at CNT_W+1 bits so max ratio never wraps.

Decomposition:
- Package clk_div_mon_pkg holds:
  - state enum mon_state_e {ACQ, LOCKED};
  - localparam for mcnt width, $clog2(LOCK_CNT+1).
- Sub-module sync_rise_det holds the 2-flop synchroniser, history flop and rise/level outputs, with async active-low reset. It is reusable for other clock-crossing status inputs.

Test Plan:
- Ideal divide-by-3 waveform (high 2 / low 1 samples), cfg_ratio=3, LOCK_CNT=4:
  - period_vld_o every 3 cycles;
  - period_o=3, high_o=2;
  - locked_o rises 1 cycle after the 4th valid period;
  - err_o never asserts.
- Locked at ratio 3, then one period stretched to 4:
  - err_o pulses once, on the cycle cnt reaches 4;
  - locked_o falls;
  - the next vld shows period_o=4;
  - relock after 4 further periods of 3.
- Locked, then div_clk_i held low:
  - single err_o pulse;
  - dead_o asserts after 255 cycles (CNT_W=8).
  - On restart, dead_o clears at the first detected rise with no vld; the first vld comes on the second rise.
- cfg_ratio=1 with a divide-by-2 waveform:
  - period_o=2 is reported;
  - locked_o stays 0 and err_o stays 0 indefinitely.
- rst_n asserted asynchronously mid-period while locked:
  - all outputs 0 within the same cycle, with no err_o;
  - after release, the first vld comes on the second rise and lock follows after 4 matches.
- Alternating periods 3/4 with cfg_ratio=3:
  - mcnt never exceeds 1;
  - locked_o stays 0;
  - period_o alternates 3, 4.
